// File: rtl/mm_match_ctrl.sv
// Matching-memory sequencer: classifies each token against a tag table and drives the stage's WR_E/DEL/ADDR.
// Defining MMCTRL_STATS_EN adds wrap-around fire/store/collision counters (stat_fire, stat_store, stat_coll).
module mm_match_ctrl #(
    parameter int DEPTH = 64,
    parameter int AW    = 6,
    parameter int PW    = 38
) (
    input  logic          CP,
    input  logic          MR_N,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [PW-1:0] in_packet,
    output logic          cmd_valid,
    input  logic          cmd_ready,
    output logic          cmd_wr_e,
    output logic          cmd_del,
    output logic [AW-1:0] cmd_addr,
    output logic [PW-1:0] cmd_packet,
    output logic          ovf_valid,
    input  logic          ovf_ready,
    output logic [PW-1:0] ovf_packet,
    input  logic          flush,
    output logic [AW:0]   occupancy
`ifdef MMCTRL_STATS_EN
    ,
    output logic [15:0]   stat_fire,
    output logic [15:0]   stat_store,
    output logic [15:0]   stat_coll
`endif
);
    localparam int          TL       = 20;
    localparam int          TW       = PW - TL;
    localparam logic [AW:0] OCC_MAX  = (AW+1)'(DEPTH);
    localparam logic [AW:0] OCC_ONE  = (AW+1)'(1);
    localparam logic [AW:0] OCC_ZERO = (AW+1)'(0);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOOKUP = 2'd1,
        ISSUE  = 2'd2,
        OVF    = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        K_BYPASS = 2'd0,
        K_STORE  = 2'd1,
        K_FIRE   = 2'd2
    } kind_t;

    // Entry index folds the two low 6-bit groups of the tag together.
    function automatic logic [AW-1:0] f_idx(input logic [PW-1:0] pkt);
        return pkt[TL +: AW] ^ pkt[TL+AW +: AW];
    endfunction

    state_t          state_r;
    kind_t           kind_r;
    logic [PW-1:0]   pkt_r;
    logic            live_r;
    logic            flush_pend_r;
    logic [DEPTH-1:0] valid_r;
    logic [TW-1:0]   tag_r [DEPTH];
    logic [AW:0]     occ_r;
    logic            cmd_valid_r;
    logic            cmd_wr_e_r;
    logic            cmd_del_r;
    logic [AW-1:0]   cmd_addr_r;
    logic [PW-1:0]   cmd_packet_r;
    logic            ovf_valid_r;
    logic [PW-1:0]   ovf_packet_r;

    logic [AW-1:0]   idx_s;
    logic            hit_s;
    logic            tag_eq_s;
    logic            flush_now_s;
    logic            issue_done_s;
    logic            ovf_done_s;

    // Lookup of the captured packet and handshake qualifiers
    always_comb begin
        idx_s        = f_idx(pkt_r);
        hit_s        = valid_r[idx_s];
        tag_eq_s     = (tag_r[idx_s] == pkt_r[PW-1:TL]);
        flush_now_s  = (state_r == IDLE) && (flush || flush_pend_r);
        issue_done_s = (state_r == ISSUE) && cmd_ready;
        ovf_done_s   = (state_r == OVF) && ovf_ready;
    end

    // Ready depends only on state and flush, never on the downstream readies.
    assign in_ready   = live_r && (state_r == IDLE) && !flush && !flush_pend_r;
    assign cmd_valid  = cmd_valid_r;
    assign cmd_wr_e   = cmd_wr_e_r;
    assign cmd_del    = cmd_del_r;
    assign cmd_addr   = cmd_addr_r;
    assign cmd_packet = cmd_packet_r;
    assign ovf_valid  = ovf_valid_r;
    assign ovf_packet = ovf_packet_r;
    assign occupancy  = occ_r;

    // Sequencer state, entry table and registered stage controls
    always_ff @(posedge CP or negedge MR_N) begin
        if (!MR_N) begin
            state_r      <= IDLE;
            kind_r       <= K_BYPASS;
            pkt_r        <= {PW{1'b0}};
            live_r       <= 1'b0;
            flush_pend_r <= 1'b0;
            valid_r      <= {DEPTH{1'b0}};
            occ_r        <= OCC_ZERO;
            for (int i = 0; i < DEPTH; i++) begin
                tag_r[i] <= {TW{1'b0}};
            end
            cmd_valid_r  <= 1'b0;
            cmd_wr_e_r   <= 1'b0;
            cmd_del_r    <= 1'b0;
            cmd_addr_r   <= {AW{1'b0}};
            cmd_packet_r <= {PW{1'b0}};
            ovf_valid_r  <= 1'b0;
            ovf_packet_r <= {PW{1'b0}};
        end else begin
            live_r <= 1'b1;
            // A flush seen mid-transaction waits for the next IDLE cycle.
            if (flush && (state_r != IDLE)) begin
                flush_pend_r <= 1'b1;
            end else begin
                flush_pend_r <= flush_pend_r;
            end
            case (state_r)
                IDLE: begin
                    if (flush_now_s) begin
                        valid_r      <= {DEPTH{1'b0}};
                        occ_r        <= OCC_ZERO;
                        flush_pend_r <= 1'b0;
                    end else if (in_valid && in_ready) begin
                        pkt_r   <= in_packet;
                        state_r <= LOOKUP;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                LOOKUP: begin
                    if (!pkt_r[18]) begin
                        kind_r       <= K_BYPASS;
                        cmd_wr_e_r   <= 1'b0;
                        cmd_del_r    <= 1'b0;
                        cmd_addr_r   <= idx_s;
                        cmd_packet_r <= pkt_r;
                        cmd_valid_r  <= 1'b1;
                        state_r      <= ISSUE;
                    end else if (!hit_s) begin
                        kind_r       <= K_STORE;
                        cmd_wr_e_r   <= 1'b1;
                        cmd_del_r    <= 1'b1;
                        cmd_addr_r   <= idx_s;
                        cmd_packet_r <= pkt_r;
                        cmd_valid_r  <= 1'b1;
                        state_r      <= ISSUE;
                    end else if (tag_eq_s) begin
                        kind_r       <= K_FIRE;
                        cmd_wr_e_r   <= 1'b0;
                        cmd_del_r    <= 1'b0;
                        cmd_addr_r   <= idx_s;
                        cmd_packet_r <= pkt_r;
                        cmd_valid_r  <= 1'b1;
                        state_r      <= ISSUE;
                    end else begin
                        ovf_packet_r <= pkt_r;
                        ovf_valid_r  <= 1'b1;
                        state_r      <= OVF;
                    end
                end
                ISSUE: begin
                    if (issue_done_s) begin
                        cmd_valid_r <= 1'b0;
                        state_r     <= IDLE;
                        case (kind_r)
                            K_STORE: begin
                                valid_r[cmd_addr_r] <= 1'b1;
                                tag_r[cmd_addr_r]   <= cmd_packet_r[PW-1:TL];
                                if (occ_r != OCC_MAX) begin
                                    occ_r <= occ_r + OCC_ONE;
                                end else begin
                                    occ_r <= occ_r;
                                end
                            end
                            K_FIRE: begin
                                valid_r[cmd_addr_r] <= 1'b0;
                                if (occ_r != OCC_ZERO) begin
                                    occ_r <= occ_r - OCC_ONE;
                                end else begin
                                    occ_r <= occ_r;
                                end
                            end
                            default: begin
                                occ_r <= occ_r;
                            end
                        endcase
                    end else begin
                        state_r <= ISSUE;
                    end
                end
                OVF: begin
                    if (ovf_done_s) begin
                        ovf_valid_r <= 1'b0;
                        state_r     <= IDLE;
                    end else begin
                        state_r <= OVF;
                    end
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

`ifdef MMCTRL_STATS_EN
    logic [15:0] stat_fire_r;
    logic [15:0] stat_store_r;
    logic [15:0] stat_coll_r;

    // Outcome counters advance on completed handshakes, wrap, and survive flush
    always_ff @(posedge CP or negedge MR_N) begin
        if (!MR_N) begin
            stat_fire_r  <= 16'd0;
            stat_store_r <= 16'd0;
            stat_coll_r  <= 16'd0;
        end else begin
            if (issue_done_s && (kind_r == K_FIRE)) begin
                stat_fire_r <= stat_fire_r + 16'd1;
            end else begin
                stat_fire_r <= stat_fire_r;
            end
            if (issue_done_s && (kind_r == K_STORE)) begin
                stat_store_r <= stat_store_r + 16'd1;
            end else begin
                stat_store_r <= stat_store_r;
            end
            if (ovf_done_s) begin
                stat_coll_r <= stat_coll_r + 16'd1;
            end else begin
                stat_coll_r <= stat_coll_r;
            end
        end
    end

    assign stat_fire  = stat_fire_r;
    assign stat_store = stat_store_r;
    assign stat_coll  = stat_coll_r;
`endif

endmodule

// File: tb/tb_mm_match_ctrl.sv
// Randomised self-checking bench for mm_match_ctrl against an abstract tag-table model.
module tb_mm_match_ctrl;
    localparam int PW    = 38;
    localparam int AW    = 6;
    localparam int DEPTH = 64;

    logic          CP        = 1'b0;
    logic          MR_N      = 1'b0;
    logic          in_valid  = 1'b0;
    logic [PW-1:0] in_packet = {PW{1'b0}};
    logic          cmd_ready = 1'b0;
    logic          ovf_ready = 1'b0;
    logic          flush     = 1'b0;
    logic          in_ready;
    logic          cmd_valid;
    logic          cmd_wr_e;
    logic          cmd_del;
    logic [AW-1:0] cmd_addr;
    logic [PW-1:0] cmd_packet;
    logic          ovf_valid;
    logic [PW-1:0] ovf_packet;
    logic [AW:0]   occupancy;
`ifdef MMCTRL_STATS_EN
    logic [15:0]   stat_fire;
    logic [15:0]   stat_store;
    logic [15:0]   stat_coll;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: which entries hold a waiting operand, and its tag.
    bit          m_valid [DEPTH];
    logic [17:0] m_tag   [DEPTH];
    int          m_fire  = 0;
    int          m_store = 0;
    int          m_coll  = 0;

    mm_match_ctrl dut (
        .CP(CP), .MR_N(MR_N),
        .in_valid(in_valid), .in_ready(in_ready), .in_packet(in_packet),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_wr_e(cmd_wr_e),
        .cmd_del(cmd_del), .cmd_addr(cmd_addr), .cmd_packet(cmd_packet),
        .ovf_valid(ovf_valid), .ovf_ready(ovf_ready), .ovf_packet(ovf_packet),
        .flush(flush), .occupancy(occupancy)
`ifdef MMCTRL_STATS_EN
        , .stat_fire(stat_fire), .stat_store(stat_store), .stat_coll(stat_coll)
`endif
    );

    always #5 CP = ~CP;

    function automatic int m_count();
        int c = 0;
        for (int i = 0; i < DEPTH; i++) c += m_valid[i] ? 1 : 0;
        return c;
    endfunction

    function automatic void m_clear();
        for (int i = 0; i < DEPTH; i++) m_valid[i] = 1'b0;
    endfunction

    function automatic logic [PW-1:0] mk(input logic [17:0] tag, input logic lr, input logic mf,
                                         input logic [1:0] cz, input logic [15:0] d);
        return {tag, lr, mf, cz, d};
    endfunction

    // Send one packet; kind 0=bypass 1=store 2=fire 3=collision is predicted from the model.
    task automatic do_packet(input logic [PW-1:0] p, input int stall, input bit flush_mid, input bit abort);
        logic [17:0] tag;
        logic [5:0]  idx;
        int          kind;
        int          n;
        tag = p[37:20];
        idx = tag[5:0] ^ tag[11:6];
        if (!p[18]) kind = 0;
        else if (!m_valid[idx]) kind = 1;
        else if (m_tag[idx] == tag) kind = 2;
        else kind = 3;

        in_packet = p;
        in_valid  = 1'b1;
        n = 0;
        while (in_ready !== 1'b1 && n < 20) begin @(posedge CP); #1; n++; end
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL accept_wait: in_ready=%b required 1", in_ready);
            in_valid = 1'b0;
            return;
        end
        @(posedge CP); #1;
        in_valid  = 1'b0;
        in_packet = PW'({$urandom(), $urandom()});

        n = 0;
        while (cmd_valid !== 1'b1 && ovf_valid !== 1'b1 && n < 8) begin @(posedge CP); #1; n++; end
        n_checks++;
        if (kind == 3) begin
            if (ovf_valid !== 1'b1 || cmd_valid !== 1'b0 || ovf_packet !== p) begin
                n_fail++;
                $display("FAIL collision: ovf_valid=%b cmd_valid=%b ovf_packet=%h required 1 0 %h",
                         ovf_valid, cmd_valid, ovf_packet, p);
            end
        end else begin
            if (cmd_valid !== 1'b1 || ovf_valid !== 1'b0 || cmd_wr_e !== (kind == 1) ||
                cmd_del !== (kind == 1) || cmd_addr !== idx || cmd_packet !== p) begin
                n_fail++;
                $display("FAIL cmd_kind%0d: v=%b ov=%b we=%b del=%b addr=%h pkt=%h required 1 0 %b %b %h %h",
                         kind, cmd_valid, ovf_valid, cmd_wr_e, cmd_del, cmd_addr, cmd_packet,
                         kind == 1, kind == 1, idx, p);
            end
        end

        for (int i = 0; i < stall; i++) begin
            flush = (flush_mid && i == 0);
            @(posedge CP); #1;
            flush = 1'b0;
            n_checks++;
            if (in_ready !== 1'b0 ||
                ((kind == 3) ? (ovf_valid !== 1'b1 || ovf_packet !== p)
                             : (cmd_valid !== 1'b1 || cmd_packet !== p || cmd_addr !== idx ||
                                cmd_wr_e !== (kind == 1)))) begin
                n_fail++;
                $display("FAIL stall_hold: in_ready=%b cmd_valid=%b ovf_valid=%b addr=%h required 0 held outputs for %h",
                         in_ready, cmd_valid, ovf_valid, cmd_addr, p);
            end
        end

        if (abort) begin
            MR_N = 1'b0;
            #1;
            n_checks++;
            if (cmd_valid !== 1'b0 || ovf_valid !== 1'b0 || in_ready !== 1'b0 || occupancy !== 7'd0 ||
                cmd_addr !== 6'd0 || cmd_packet !== {PW{1'b0}} || cmd_wr_e !== 1'b0 || cmd_del !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_mid: cmd_valid=%b ovf_valid=%b in_ready=%b occ=%0d required all 0",
                         cmd_valid, ovf_valid, in_ready, occupancy);
            end
`ifdef MMCTRL_STATS_EN
            n_checks++;
            if (stat_fire !== 16'd0 || stat_store !== 16'd0 || stat_coll !== 16'd0) begin
                n_fail++;
                $display("FAIL reset_stats: %0d %0d %0d required 0 0 0", stat_fire, stat_store, stat_coll);
            end
`endif
            m_clear();
            m_fire = 0; m_store = 0; m_coll = 0;
            @(posedge CP); #1;
            MR_N = 1'b1;
            @(posedge CP); #1;
            return;
        end

        if (kind == 3) ovf_ready = 1'b1; else cmd_ready = 1'b1;
        @(posedge CP); #1;
        cmd_ready = 1'b0;
        ovf_ready = 1'b0;
        if (kind == 1) begin m_valid[idx] = 1'b1; m_tag[idx] = tag; m_store++; end
        if (kind == 2) begin m_valid[idx] = 1'b0; m_fire++; end
        if (kind == 3) m_coll++;
        n_checks++;
        if (cmd_valid !== 1'b0 || ovf_valid !== 1'b0 || in_ready !== !flush_mid) begin
            n_fail++;
            $display("FAIL post_handshake: cmd_valid=%b ovf_valid=%b in_ready=%b required 0 0 %b",
                     cmd_valid, ovf_valid, in_ready, !flush_mid);
        end
        if (flush_mid) begin
            @(posedge CP); #1;
            m_clear();
        end
        n_checks++;
        if (occupancy !== 7'(m_count()) || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL occupancy: occ=%0d in_ready=%b required %0d 1", occupancy, in_ready, m_count());
        end
`ifdef MMCTRL_STATS_EN
        n_checks++;
        if (stat_fire !== 16'(m_fire) || stat_store !== 16'(m_store) || stat_coll !== 16'(m_coll)) begin
            n_fail++;
            $display("FAIL stats: %0d %0d %0d required %0d %0d %0d",
                     stat_fire, stat_store, stat_coll, m_fire, m_store, m_coll);
        end
`endif
    endtask

    task automatic test_reset();
        MR_N = 1'b0;
        repeat (3) @(posedge CP);
        #1;
        n_checks++;
        if (in_ready !== 1'b0 || cmd_valid !== 1'b0 || ovf_valid !== 1'b0 || occupancy !== 7'd0 ||
            cmd_addr !== 6'd0 || cmd_packet !== {PW{1'b0}} || ovf_packet !== {PW{1'b0}} ||
            cmd_wr_e !== 1'b0 || cmd_del !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state: in_ready=%b cmd_valid=%b ovf_valid=%b occ=%0d required all 0",
                     in_ready, cmd_valid, ovf_valid, occupancy);
        end
        MR_N = 1'b1;
        m_clear();
        @(posedge CP); #1;
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_release: in_ready=%b required 1", in_ready);
        end
    endtask

    task automatic test_store_fire();
        do_packet(mk(18'h00041, 1'b0, 1'b1, 2'd0, 16'h1234), 0, 1'b0, 1'b0);
        do_packet(mk(18'h00041, 1'b1, 1'b1, 2'd0, 16'h0005), 0, 1'b0, 1'b0);
    endtask

    task automatic test_collision();
        do_packet(mk(18'h00041, 1'b0, 1'b1, 2'd1, 16'hAAAA), 0, 1'b0, 1'b0);
        do_packet(mk(18'h00801, 1'b0, 1'b1, 2'd2, 16'h5555), 0, 1'b0, 1'b0);
        // Same index as 18'h00041 (bits 0 and 6 both flipped) but a different tag.
        do_packet(mk(18'h00000, 1'b1, 1'b1, 2'd3, 16'hBEEF), 3, 1'b0, 1'b0);
        do_packet(mk(18'h01002, 1'b0, 1'b1, 2'd0, 16'h0001), 0, 1'b0, 1'b0);
    endtask

    task automatic test_bypass();
        do_packet(mk(18'h00041, 1'b0, 1'b0, 2'd0, 16'h00FF), 1, 1'b0, 1'b0);
        do_packet(mk(18'h3FFFF, 1'b1, 1'b0, 2'd2, 16'h00FF), 0, 1'b0, 1'b0);
    endtask

    task automatic test_flush();
        do_packet(mk(18'h00123, 1'b0, 1'b1, 2'd0, 16'h7777), 5, 1'b1, 1'b0);
        do_packet(mk(18'h00007, 1'b0, 1'b1, 2'd0, 16'h1111), 0, 1'b0, 1'b0);
        flush = 1'b1;
        #1;
        n_checks++;
        if (in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_flush_ready: in_ready=%b required 0", in_ready);
        end
        @(posedge CP); #1;
        flush = 1'b0;
        m_clear();
        #1;
        n_checks++;
        if (occupancy !== 7'd0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL idle_flush: occ=%0d in_ready=%b required 0 1", occupancy, in_ready);
        end
    endtask

    task automatic test_fill();
        for (int i = 0; i < DEPTH; i++) do_packet(mk(18'(i), 1'b0, 1'b1, 2'd0, 16'(i)), 0, 1'b0, 1'b0);
        n_checks++;
        if (occupancy !== 7'd64) begin
            n_fail++;
            $display("FAIL full: occ=%0d required 64", occupancy);
        end
        for (int i = 0; i < DEPTH; i++) do_packet(mk(18'(i), 1'b1, 1'b1, 2'd0, 16'(i)), 0, 1'b0, 1'b0);
        n_checks++;
        if (occupancy !== 7'd0) begin
            n_fail++;
            $display("FAIL empty: occ=%0d required 0", occupancy);
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 60; k++) begin
            logic [17:0]   t;
            logic [PW-1:0] p;
            t = 18'($urandom_range(0, 15)) | (18'($urandom_range(0, 1)) << 12);
            p = mk(t, 1'($urandom_range(0, 1)), ($urandom_range(0, 9) < 8) ? 1'b1 : 1'b0,
                   2'($urandom_range(0, 3)), 16'($urandom()));
            do_packet(p, $urandom_range(0, 2), 1'b0, 1'b0);
        end
    endtask

    task automatic test_reset_mid();
        do_packet(mk(18'h00055, 1'b0, 1'b1, 2'd0, 16'h4242), 2, 1'b0, 1'b0);
        do_packet(mk(18'h00066, 1'b0, 1'b1, 2'd0, 16'h4343), 2, 1'b0, 1'b1);
        do_packet(mk(18'h00055, 1'b1, 1'b1, 2'd0, 16'h0001), 0, 1'b0, 1'b0);
    endtask

    initial begin
        test_reset();
        test_store_fire();
        test_collision();
        test_bypass();
        test_flush();
        test_fill();
        test_random();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
